// File: rtl/cordic_quadrant_ctrl.sv
// cordic_quadrant_ctrl
//   Control wrapper around an iterative CORDIC sine/cosine core. An accepted
//   angle is reduced modulo 360 degrees, folded into the first quadrant and
//   handed to the core. When the core reports done, its sine/cosine are
//   mapped back to the original quadrant (swap and saturating negate).
//
// Ports
//   Clk_i         clock, all logic on posedge
//   Rst_i         synchronous active-high reset
//   Angle_i       unsigned full-circle angle code (full 16-bit range)
//   Valid_i       request, taken only while Ready_o is high
//   Ready_o       high in IDLE when not in reset
//   Sine_o        corrected sine (two's complement), held until next Valid_o
//   Cos_o         corrected cosine (two's complement), held until next Valid_o
//   Valid_o       one-cycle pulse marking new Sine_o/Cos_o
//   Err_o         one-cycle pulse when the core fails to finish in time
//   Core_Angle_o  folded angle in [0, ANG_90) for the core
//   Core_Start_o  one-cycle start pulse to the core
//   Core_Done_i   core done level
//   Core_Sine_i   core sine result
//   Core_Cos_i    core cosine result
module cordic_quadrant_ctrl #(
  parameter int          DATA_W  = 16,
  parameter logic [15:0] ANG_90  = 16'h147A,
  parameter logic [15:0] ANG_180 = 16'h28F4,
  parameter logic [15:0] ANG_270 = 16'h3D6E,
  parameter logic [15:0] ANG_360 = 16'h51E8,
  parameter int          TIMEOUT = 63
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic [15:0]       Angle_i,
  input  logic              Valid_i,
  output logic              Ready_o,
  output logic [DATA_W-1:0] Sine_o,
  output logic [DATA_W-1:0] Cos_o,
  output logic              Valid_o,
  output logic              Err_o,
  output logic [15:0]       Core_Angle_o,
  output logic              Core_Start_o,
  input  logic              Core_Done_i,
  input  logic [DATA_W-1:0] Core_Sine_i,
  input  logic [DATA_W-1:0] Core_Cos_i
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_START,
    S_ARM,
    S_WAIT
  } state_t;

  state_t                    state_q, state_d;
  logic [15:0]               ang_q, ang_d;
  logic [1:0]                quad_q, quad_d;
  logic [15:0]               core_ang_q, core_ang_d;
  logic signed [DATA_W-1:0]  sine_q, sine_d;
  logic signed [DATA_W-1:0]  cos_q, cos_d;
  logic                      valid_q, valid_d;
  logic                      err_q, err_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic signed [DATA_W-1:0]  core_s;
  logic signed [DATA_W-1:0]  core_c;
  logic [1:0]                quad_c;

  // Two's complement negate; the most negative code has no positive
  // counterpart, so it clamps to the most positive code.
  function automatic logic signed [DATA_W-1:0] neg_sat(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] min_v;
    min_v = {1'b1, {(DATA_W-1){1'b0}}};
    if (x == min_v) begin
      neg_sat = ~min_v;
    end else begin
      neg_sat = -x;
    end
  endfunction

  // Quadrant of a reduced angle; exact boundaries belong to the upper quadrant.
  function automatic logic [1:0] quadrant(input logic [15:0] a);
    if (a < ANG_90) begin
      quadrant = 2'd0;
    end else if (a < ANG_180) begin
      quadrant = 2'd1;
    end else if (a < ANG_270) begin
      quadrant = 2'd2;
    end else begin
      quadrant = 2'd3;
    end
  endfunction

  assign core_s = Core_Sine_i;
  assign core_c = Core_Cos_i;
  assign quad_c = quadrant(ang_q);

  always_comb begin
    state_d    = state_q;
    ang_d      = ang_q;
    quad_d     = quad_q;
    core_ang_d = core_ang_q;
    sine_d     = sine_q;
    cos_d      = cos_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (Valid_i) begin
          ang_d   = Angle_i;
          state_d = S_REDUCE;
        end
      end

      // Modulo-360 by repeated subtraction (at most 3 passes for 16'hFFFF),
      // then fold into the first quadrant.
      S_REDUCE: begin
        if (ang_q >= ANG_360) begin
          ang_d = ang_q - ANG_360;
        end else begin
          quad_d = quad_c;
          case (quad_c)
            2'd0:    core_ang_d = ang_q;
            2'd1:    core_ang_d = ang_q - ANG_90;
            2'd2:    core_ang_d = ang_q - ANG_180;
            default: core_ang_d = ang_q - ANG_270;
          endcase
          state_d = S_START;
        end
      end

      // Launch the core
      S_START: begin
        cnt_d   = '0;
        state_d = S_ARM;
      end

      // Done is not looked at here so a level left over from the previous
      // run cannot complete this one.
      S_ARM: begin
        state_d = S_WAIT;
      end

      // Wait for completion; done takes priority over an expiring counter.
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (Core_Done_i) begin
          case (quad_q)
            2'd0: begin
              sine_d = core_s;
              cos_d  = core_c;
            end
            2'd1: begin
              sine_d = core_c;
              cos_d  = neg_sat(core_s);
            end
            2'd2: begin
              sine_d = neg_sat(core_s);
              cos_d  = neg_sat(core_c);
            end
            default: begin
              sine_d = neg_sat(core_c);
              cos_d  = core_s;
            end
          endcase
          valid_d = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q    <= S_IDLE;
      ang_q      <= '0;
      quad_q     <= '0;
      core_ang_q <= '0;
      sine_q     <= '0;
      cos_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ang_q      <= ang_d;
      quad_q     <= quad_d;
      core_ang_q <= core_ang_d;
      sine_q     <= sine_d;
      cos_q      <= cos_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign Ready_o      = (state_q == S_IDLE) && !Rst_i;
  assign Core_Start_o = (state_q == S_START);
  assign Core_Angle_o = core_ang_q;
  assign Sine_o       = sine_q;
  assign Cos_o        = cos_q;
  assign Valid_o      = valid_q;
  assign Err_o        = err_q;

endmodule

// File: tb/tb_cordic_quadrant_ctrl.sv
// Testbench for cordic_quadrant_ctrl: directed requests against a simple
// core model that answers 20 cycles after start with fixed sine/cosine.
module tb_cordic_quadrant_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] angle;
  logic        valid_in;
  logic        ready;
  logic [15:0] sine;
  logic [15:0] cosv;
  logic        valid_out;
  logic        err;
  logic [15:0] core_angle;
  logic        core_start;
  logic        core_done = 1'b0;
  logic [15:0] core_s;
  logic [15:0] core_c;

  int  core_cnt = 0;
  bit  core_hang;
  int  chk_cnt;
  int  pass_cnt;

  always #5 clk = ~clk;

  cordic_quadrant_ctrl dut (
    .Clk_i        (clk),
    .Rst_i        (rst),
    .Angle_i      (angle),
    .Valid_i      (valid_in),
    .Ready_o      (ready),
    .Sine_o       (sine),
    .Cos_o        (cosv),
    .Valid_o      (valid_out),
    .Err_o        (err),
    .Core_Angle_o (core_angle),
    .Core_Start_o (core_start),
    .Core_Done_i  (core_done),
    .Core_Sine_i  (core_s),
    .Core_Cos_i   (core_c)
  );

  // Core model: done drops on start and rises 20 cycles later (unless hung).
  always @(posedge clk) begin
    if (core_start) begin
      core_done <= 1'b0;
      core_cnt  <= 20;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1 && !core_hang) core_done <= 1'b1;
    end
  end

  // Present a request at the current negedge and follow it; cycle 1 is the
  // first cycle after the accepting edge. Returns -1 for events not seen.
  task automatic issue(input logic [15:0] ang, input int budget,
                       output int t_start, output int t_valid, output int t_err,
                       output logic [15:0] cang);
    angle    = ang;
    valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    angle    = 16'h5A5A;
    t_start  = -1;
    t_valid  = -1;
    t_err    = -1;
    cang     = 16'h0;
    for (int n = 1; n <= budget; n++) begin
      if (core_start && t_start < 0) begin
        t_start = n;
        cang    = core_angle;
      end
      if (valid_out) begin
        t_valid = n;
        break;
      end
      if (err) begin
        t_err = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; angle = 16'h0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", ready); else pass_cnt++;
    chk_cnt++; if ({valid_out, err, core_start} !== 3'b000) $display("FAIL rst_pulses: got %b want 000", {valid_out, err, core_start}); else pass_cnt++;
    chk_cnt++; if ({sine, cosv, core_angle} !== 48'h0) $display("FAIL rst_data: got %h want 0", {sine, cosv, core_angle}); else pass_cnt++;
    rst = 1'b0;
    #1;
    chk_cnt++; if (ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", ready); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_quadrants();
    int ts, tv, te; logic [15:0] ca;
    // 45 deg, q0
    issue(16'h0A3D, 40, ts, tv, te, ca);
    chk_cnt++; if (ts !== 2) $display("FAIL q0_start_lat: got %0d want 2", ts); else pass_cnt++;
    chk_cnt++; if (ca !== 16'h0A3D) $display("FAIL q0_core_ang: got %h want 0a3d", ca); else pass_cnt++;
    chk_cnt++; if (tv !== 24) $display("FAIL q0_valid_lat: got %0d want 24", tv); else pass_cnt++;
    chk_cnt++; if ({sine, cosv} !== {16'h1000, 16'h1800}) $display("FAIL q0_out: got %h want 10001800", {sine, cosv}); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({valid_out, ready} !== 2'b01) $display("FAIL q0_pulse_end: got %b want 01", {valid_out, ready}); else pass_cnt++;
    // 225 deg, q2
    issue(16'h3331, 40, ts, tv, te, ca);
    chk_cnt++; if (ca !== 16'h0A3D) $display("FAIL q2_core_ang: got %h want 0a3d", ca); else pass_cnt++;
    chk_cnt++; if (tv !== 24) $display("FAIL q2_valid_lat: got %0d want 24", tv); else pass_cnt++;
    chk_cnt++; if ({sine, cosv} !== {16'hF000, 16'hE800}) $display("FAIL q2_out: got %h want f000e800", {sine, cosv}); else pass_cnt++;
    @(negedge clk);
    // exactly 90 deg, q1
    issue(16'h147A, 40, ts, tv, te, ca);
    chk_cnt++; if (ca !== 16'h0000) $display("FAIL q1_core_ang: got %h want 0000", ca); else pass_cnt++;
    chk_cnt++; if ({sine, cosv} !== {16'h1800, 16'hF000}) $display("FAIL q1_out: got %h want 1800f000", {sine, cosv}); else pass_cnt++;
    @(negedge clk);
    // exactly 270 deg, q3
    issue(16'h3D6E, 40, ts, tv, te, ca);
    chk_cnt++; if (ca !== 16'h0000) $display("FAIL q3_core_ang: got %h want 0000", ca); else pass_cnt++;
    chk_cnt++; if ({sine, cosv} !== {16'hE800, 16'h1000}) $display("FAIL q3_out: got %h want e8001000", {sine, cosv}); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reduce();
    int ts, tv, te; logic [15:0] ca;
    issue(16'hFFFF, 40, ts, tv, te, ca);
    chk_cnt++; if (ts !== 5) $display("FAIL ffff_start_lat: got %0d want 5", ts); else pass_cnt++;
    chk_cnt++; if (ca !== 16'h0A47) $display("FAIL ffff_core_ang: got %h want 0a47", ca); else pass_cnt++;
    chk_cnt++; if (tv !== 27) $display("FAIL ffff_valid_lat: got %0d want 27", tv); else pass_cnt++;
    chk_cnt++; if ({sine, cosv} !== {16'h1000, 16'h1800}) $display("FAIL ffff_out: got %h want 10001800", {sine, cosv}); else pass_cnt++;
    @(negedge clk);
    issue(16'h51E8, 40, ts, tv, te, ca);
    chk_cnt++; if (ts !== 3) $display("FAIL 360_start_lat: got %0d want 3", ts); else pass_cnt++;
    chk_cnt++; if (ca !== 16'h0000) $display("FAIL 360_core_ang: got %h want 0000", ca); else pass_cnt++;
    chk_cnt++; if (tv !== 25) $display("FAIL 360_valid_lat: got %0d want 25", tv); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int ts, tv, te; logic [15:0] ca;
    issue(16'h0A3D, 40, ts, tv, te, ca);
    chk_cnt++; if ({valid_out, ready} !== 2'b11) $display("FAIL b2b_ready_with_valid: got %b want 11", {valid_out, ready}); else pass_cnt++;
    // 135 deg accepted in the Valid_o cycle
    issue(16'h1EB7, 40, ts, tv, te, ca);
    chk_cnt++; if (ca !== 16'h0A3D) $display("FAIL b2b_core_ang: got %h want 0a3d", ca); else pass_cnt++;
    chk_cnt++; if (tv !== 24) $display("FAIL b2b_valid_lat: got %0d want 24", tv); else pass_cnt++;
    chk_cnt++; if ({sine, cosv} !== {16'h1800, 16'hF000}) $display("FAIL b2b_out: got %h want 1800f000", {sine, cosv}); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int ts, tv, te; logic [15:0] ca;
    core_hang = 1'b1;
    issue(16'h0A3D, 100, ts, tv, te, ca);
    chk_cnt++; if (te !== 67) $display("FAIL to_err_lat: got %0d want 67", te); else pass_cnt++;
    chk_cnt++; if (tv !== -1) $display("FAIL to_no_valid: got %0d want -1", tv); else pass_cnt++;
    chk_cnt++; if ({sine, cosv} !== {16'h1800, 16'hF000}) $display("FAIL to_out_held: got %h want 1800f000", {sine, cosv}); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({err, ready} !== 2'b01) $display("FAIL to_pulse_end: got %b want 01", {err, ready}); else pass_cnt++;
    core_hang = 1'b0;
  endtask

  task automatic test_saturation();
    int ts, tv, te; logic [15:0] ca;
    core_s = 16'h8000;
    issue(16'h3331, 40, ts, tv, te, ca);
    chk_cnt++; if (tv !== 24) $display("FAIL sat_valid_lat: got %0d want 24", tv); else pass_cnt++;
    chk_cnt++; if ({sine, cosv} !== {16'h7FFF, 16'hE800}) $display("FAIL sat_out: got %h want 7fffe800", {sine, cosv}); else pass_cnt++;
    core_s = 16'h1000;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int ts, tv, te; int seen; logic [15:0] ca;
    angle = 16'h0A3D; valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_cnt++; if (ready !== 1'b0) $display("FAIL mid_ready_in_rst: got %b want 0", ready); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_cnt++; if ({sine, cosv, core_angle} !== 48'h0) $display("FAIL mid_data_cleared: got %h want 0", {sine, cosv, core_angle}); else pass_cnt++;
    chk_cnt++; if ({valid_out, err, core_start, ready} !== 4'b0001) $display("FAIL mid_ctrl: got %b want 0001", {valid_out, err, core_start, ready}); else pass_cnt++;
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (valid_out || err) seen++;
    end
    chk_cnt++; if (seen !== 0) $display("FAIL mid_no_result: got %0d pulses want 0", seen); else pass_cnt++;
    issue(16'h0A3D, 40, ts, tv, te, ca);
    chk_cnt++; if (tv !== 24) $display("FAIL mid_next_lat: got %0d want 24", tv); else pass_cnt++;
    chk_cnt++; if ({sine, cosv} !== {16'h1000, 16'h1800}) $display("FAIL mid_next_out: got %h want 10001800", {sine, cosv}); else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    chk_cnt   = 0;
    pass_cnt  = 0;
    core_hang = 1'b0;
    core_s    = 16'h1000;
    core_c    = 16'h1800;
    rst       = 1'b1;
    valid_in  = 1'b0;
    angle     = 16'h0;
    @(negedge clk);
    test_reset();
    test_quadrants();
    test_reduce();
    test_back_to_back();
    test_timeout();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
